// File: rtl/uart_rib_master.sv
// uart_rib_master: debug bridge from USART command bytes to single RIB transactions.
// Frames are 'W' + addr[4] + data[4] or 'R' + addr[4], all fields LSB first.
// A write replies ACK_BYTE. A read replies the 32-bit read data, LSB first.
// Optional macro RIB_TIMEOUT_EN aborts a stalled gnt/rsp after TIMEOUT_CYC cycles and replies ERR_BYTE.
// Ports:
//   i_clk/i_rst            : clock; asynchronous active-high reset.
//   i_rx_vld/i_rx_data     : byte stream from the USART receiver.
//   i_tx_rdy/o_tx_en/o_tx_data : byte stream to the USART transmitter.
//   o_ribm_* / i_ribm_*    : RIB initiator port (req/gnt handshake, then rdy/rsp handshake).
//   o_busy                 : high whenever the FSM is not idle.
module uart_rib_master #(
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [7:0] ACK_BYTE    = 8'h4B,
  parameter logic [7:0] ERR_BYTE    = 8'h45
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_vld,
  input  logic [7:0]  i_rx_data,
  input  logic        i_tx_rdy,
  output logic        o_tx_en,
  output logic [7:0]  o_tx_data,
  output logic [31:0] o_ribm_addr,
  output logic        o_ribm_wrcs,
  output logic [3:0]  o_ribm_mask,
  output logic [31:0] o_ribm_wdata,
  input  logic [31:0] i_ribm_rdata,
  output logic        o_ribm_req,
  input  logic        i_ribm_gnt,
  input  logic        i_ribm_rsp,
  output logic        o_ribm_rdy,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT_RSP, S_TX, S_TX_WAIT
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_bcnt;
  logic        r_wrcs;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_txsh;   // reply bytes; the low byte is the next one sent
  logic [2:0]  r_txcnt;  // reply bytes still to send
  logic [3:0]  r_mask;
  logic        w_cmd_ok;
  logic        w_tmo_hit;

  assign w_cmd_ok = (i_rx_data == 8'h57) || (i_rx_data == 8'h52);

`ifdef RIB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] r_tmo;

  // Starts at 0 in the first REQ cycle and runs through WAIT_RSP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_tmo <= '0;
    else if (w_next == S_REQ && r_state != S_REQ)
      r_tmo <= '0;
    else if (r_state == S_REQ || r_state == S_WAIT_RSP)
      r_tmo <= r_tmo + 1'b1;
  end

  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic. gnt/rsp are tested before the timeout so they win
  // in the terminal-count cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_rx_vld && w_cmd_ok) w_next = S_ADDR;
      S_ADDR:     if (i_rx_vld && r_bcnt == 2'd3) w_next = r_wrcs ? S_DATA : S_REQ;
      S_DATA:     if (i_rx_vld && r_bcnt == 2'd3) w_next = S_REQ;
      S_REQ:      if (i_ribm_gnt) w_next = S_WAIT_RSP;
                  else if (w_tmo_hit) w_next = S_TX;
      S_WAIT_RSP: if (i_ribm_rsp || w_tmo_hit) w_next = S_TX;
      S_TX:       if (i_tx_rdy) w_next = S_TX_WAIT;
      S_TX_WAIT:  w_next = (r_txcnt != 3'd0) ? S_TX : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy     = (r_state != S_IDLE);
    o_ribm_req = (r_state == S_REQ);
    o_ribm_rdy = (r_state == S_WAIT_RSP);
    o_tx_en    = (r_state == S_TX) && i_tx_rdy;
  end

  assign o_tx_data    = r_txsh[7:0];
  assign o_ribm_addr  = r_addr;
  assign o_ribm_wrcs  = r_wrcs;
  assign o_ribm_wdata = r_wdata;
  assign o_ribm_mask  = r_mask;

  // Frame capture and reply queue
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bcnt  <= 2'd0;
      r_wrcs  <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_txsh  <= 32'h0;
      r_txcnt <= 3'd0;
      r_mask  <= 4'h0;
    end else begin
      // Mask is 0 only while in reset, full-word otherwise.
      r_mask <= 4'hF;
      case (r_state)
        S_IDLE: if (i_rx_vld && w_cmd_ok) begin
          r_wrcs <= (i_rx_data == 8'h57);
          r_bcnt <= 2'd0;
        end
        S_ADDR: if (i_rx_vld) begin
          r_addr[{r_bcnt, 3'b000} +: 8] <= i_rx_data;
          r_bcnt <= r_bcnt + 2'd1;
        end
        S_DATA: if (i_rx_vld) begin
          r_wdata[{r_bcnt, 3'b000} +: 8] <= i_rx_data;
          r_bcnt <= r_bcnt + 2'd1;
        end
        S_REQ: if (!i_ribm_gnt && w_tmo_hit) begin
          r_txsh  <= {24'h0, ERR_BYTE};
          r_txcnt <= 3'd1;
        end
        S_WAIT_RSP: begin
          if (i_ribm_rsp) begin
            r_txsh  <= r_wrcs ? {24'h0, ACK_BYTE} : i_ribm_rdata;
            r_txcnt <= r_wrcs ? 3'd1 : 3'd4;
          end else if (w_tmo_hit) begin
            r_txsh  <= {24'h0, ERR_BYTE};
            r_txcnt <= 3'd1;
          end
        end
        S_TX: if (i_tx_rdy) begin
          r_txsh  <= {8'h0, r_txsh[31:8]};
          r_txcnt <= r_txcnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rib_master.sv
module tb_uart_rib_master;
  localparam int TMO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_rx_vld = 1'b0;
  logic [7:0]  i_rx_data = 8'h0;
  logic        i_tx_rdy = 1'b1;
  logic        o_tx_en;
  logic [7:0]  o_tx_data;
  logic [31:0] o_ribm_addr;
  logic        o_ribm_wrcs;
  logic [3:0]  o_ribm_mask;
  logic [31:0] o_ribm_wdata;
  logic [31:0] i_ribm_rdata = 32'h0;
  logic        o_ribm_req;
  logic        i_ribm_gnt = 1'b0;
  logic        i_ribm_rsp = 1'b0;
  logic        o_ribm_rdy;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  uart_rib_master #(.TIMEOUT_CYC(TMO), .ACK_BYTE(8'h4B), .ERR_BYTE(8'h45)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rx_vld(i_rx_vld), .i_rx_data(i_rx_data),
    .i_tx_rdy(i_tx_rdy), .o_tx_en(o_tx_en), .o_tx_data(o_tx_data),
    .o_ribm_addr(o_ribm_addr), .o_ribm_wrcs(o_ribm_wrcs), .o_ribm_mask(o_ribm_mask),
    .o_ribm_wdata(o_ribm_wdata), .i_ribm_rdata(i_ribm_rdata),
    .o_ribm_req(o_ribm_req), .i_ribm_gnt(i_ribm_gnt), .i_ribm_rsp(i_ribm_rsp),
    .o_ribm_rdy(o_ribm_rdy), .o_busy(o_busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } req_t;

  logic [7:0] frame[$];
  req_t       exp_req[$];
  logic       pend_wr[$];
  logic [7:0] exp_tx[$];

  // Collects command bytes; a complete frame becomes one expected RIB request.
  function automatic void model_rx(input logic [7:0] b);
    req_t r;
    if (frame.size() == 0 && b != 8'h57 && b != 8'h52) return;
    frame.push_back(b);
    if ((frame[0] == 8'h57 && frame.size() == 9) || (frame[0] == 8'h52 && frame.size() == 5)) begin
      r.wr    = (frame[0] == 8'h57);
      r.addr  = {frame[4], frame[3], frame[2], frame[1]};
      r.wdata = r.wr ? {frame[8], frame[7], frame[6], frame[5]} : 32'h0;
      exp_req.push_back(r);
      pend_wr.push_back(r.wr);
      frame.delete();
    end
  endfunction

  function automatic void model_rsp(input logic [31:0] rdata);
    logic wr;
    wr = pend_wr.pop_front();
    if (wr) exp_tx.push_back(8'h4B);
    else for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
  endfunction

  function automatic void model_timeout();
    void'(pend_wr.pop_front());
    exp_tx.push_back(8'h45);
  endfunction

  function automatic void model_reset();
    frame.delete();
  endfunction

  // ---------------- compare process ----------------
  req_t       req_log[$];
  int         req_lens[$];
  logic [7:0] tx_log[$];
  int         tx_seen = 0;

  initial begin
    logic prev_req;
    req_t cur;
    req_t held;
    int   req_len;
    prev_req = 1'b0;
    req_len  = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_req = 1'b0;
      end else begin
        if (o_ribm_req) begin
          held = '{addr: o_ribm_addr, wr: o_ribm_wrcs, wdata: o_ribm_wdata};
          if (!prev_req) begin
            if (exp_req.size() == 0) fail_now("unexpected_req");
            else begin
              cur = exp_req.pop_front();
              check("req_addr", o_ribm_addr, cur.addr);
              check("req_wrcs", {31'h0, o_ribm_wrcs}, {31'h0, cur.wr});
              if (cur.wr) check("req_wdata", o_ribm_wdata, cur.wdata);
            end
            check("req_mask", {28'h0, o_ribm_mask}, 32'hF);
            req_log.push_back(held);
            req_len = 1;
          end else begin
            check("req_stable_addr", o_ribm_addr, req_log[$].addr);
            check("req_stable_wdata", o_ribm_wdata, req_log[$].wdata);
            check("req_stable_wrcs", {31'h0, o_ribm_wrcs}, {31'h0, req_log[$].wr});
            req_len++;
          end
        end else if (prev_req) begin
          req_lens.push_back(req_len);
        end
        prev_req = o_ribm_req;

        if (o_tx_en) begin
          check("tx_en_needs_rdy", {31'h0, i_tx_rdy}, 32'h1);
          if (exp_tx.size() == 0) fail_now("unexpected_tx");
          else check("tx_byte", {24'h0, o_tx_data}, {24'h0, exp_tx.pop_front()});
          tx_log.push_back(o_tx_data);
          tx_seen++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_vld  = 1'b1;
    i_rx_data = b;
    model_rx(b);
    tick();
    i_rx_vld  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!o_ribm_req && n < 100) begin
      tick();
      n++;
    end
    ok = o_ribm_req;
    if (!ok) fail_now("timeout_waiting_req");
  endtask

  // Grants after gnt_dly req cycles, then responds rsp_dly cycles into WAIT_RSP.
  task automatic serve(input int gnt_dly, input int rsp_dly, input logic [31:0] rdata);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    repeat (gnt_dly) tick();
    i_ribm_gnt = 1'b1;
    tick();
    i_ribm_gnt = 1'b0;
    check("rdy_after_gnt", {31'h0, o_ribm_rdy}, 32'h1);
    repeat (rsp_dly) tick();
    i_ribm_rsp   = 1'b1;
    i_ribm_rdata = rdata;
    model_rsp(rdata);
    tick();
    i_ribm_rsp   = 1'b0;
    i_ribm_rdata = 32'hFFFF_FFFF;
    check("rdy_after_rsp", {31'h0, o_ribm_rdy}, 32'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 200) begin
      tick();
      n++;
    end
    if (o_busy) fail_now("timeout_waiting_idle");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'h0, o_busy}, 32'h0);
    check({tag, "_req"},   {31'h0, o_ribm_req}, 32'h0);
    check({tag, "_rdy"},   {31'h0, o_ribm_rdy}, 32'h0);
    check({tag, "_txen"},  {31'h0, o_tx_en}, 32'h0);
    check({tag, "_txd"},   {24'h0, o_tx_data}, 32'h0);
    check({tag, "_addr"},  o_ribm_addr, 32'h0);
    check({tag, "_wdata"}, o_ribm_wdata, 32'h0);
    check({tag, "_wrcs"},  {31'h0, o_ribm_wrcs}, 32'h0);
    check({tag, "_mask"},  {28'h0, o_ribm_mask}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int frozen;
    int n;
    bit ok;

    repeat (3) tick();
    check_all_zero("reset");
    i_rst = 1'b0;
    tick();
    check("mask_after_reset", {28'h0, o_ribm_mask}, 32'hF);

    // Write, immediate grant
    send_frame('{8'h57, 8'h10, 8'h00, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    serve(0, 2, 32'h0);
    wait_idle();
    check("w1_addr_lit",  req_log[0].addr, 32'h2000_0010);
    check("w1_wdata_lit", req_log[0].wdata, 32'hDEAD_BEEF);
    check("w1_wr_lit",    {31'h0, req_log[0].wr}, 32'h1);
    check("w1_reqlen",    req_lens[0], 1);
    check("w1_txcount",   tx_log.size(), 1);
    check("w1_ack_lit",   {24'h0, tx_log[0]}, 32'h4B);

    // Read, grant delayed by 5 cycles
    send_frame('{8'h52, 8'h00, 8'h01, 8'h00, 8'h00});
    serve(5, 3, 32'h1234_5678);
    wait_idle();
    check("r1_addr_lit", req_log[1].addr, 32'h0000_0100);
    check("r1_wr_lit",   {31'h0, req_log[1].wr}, 32'h0);
    check("r1_reqlen",   req_lens[1], 6);
    check("r1_b0", {24'h0, tx_log[1]}, 32'h78);
    check("r1_b1", {24'h0, tx_log[2]}, 32'h56);
    check("r1_b2", {24'h0, tx_log[3]}, 32'h34);
    check("r1_b3", {24'h0, tx_log[4]}, 32'h12);

    // Garbage prefix, then a read
    send_frame('{8'h00, 8'hFF, 8'h41});
    repeat (3) tick();
    check("garbage_busy", {31'h0, o_busy}, 32'h0);
    check("garbage_noreq", req_log.size(), 2);
    send_frame('{8'h52, 8'h04, 8'h00, 8'h00, 8'h30});
    serve(1, 1, 32'hA5A5_0F0F);
    wait_idle();
    check("g_addr_lit", req_log[2].addr, 32'h3000_0004);

    // Reset in the middle of a write frame
    send_frame('{8'h57, 8'hAA, 8'hBB, 8'hCC});
    i_rst = 1'b1;
    model_reset();
    tick();
    check_all_zero("midrst");
    tick();
    i_rst = 1'b0;
    tick();
    check("post_rst_busy", {31'h0, o_busy}, 32'h0);
    send_frame('{8'h57, 8'h44, 8'h33, 8'h22, 8'h11, 8'h04, 8'h03, 8'h02, 8'h01});
    serve(2, 0, 32'h0);
    wait_idle();
    check("rst_w_addr_lit",  req_log[3].addr, 32'h1122_3344);
    check("rst_w_wdata_lit", req_log[3].wdata, 32'h0102_0304);
    check("rst_w_reqcount",  req_log.size(), 4);

    // Transmitter backpressure during a read reply
    send_frame('{8'h52, 8'h08, 8'h00, 8'h00, 8'h00});
    base = tx_seen;
    serve(0, 0, 32'hCAFE_F00D);
    n = 0;
    while (tx_seen == base && n < 20) begin
      tick();
      n++;
    end
    check("bp_first_byte", tx_seen - base, 1);
    i_tx_rdy = 1'b0;
    frozen = tx_seen;
    repeat (50) tick();
    check("bp_no_tx", tx_seen, frozen);
    check("bp_busy", {31'h0, o_busy}, 32'h1);
    i_tx_rdy = 1'b1;
    wait_idle();
    check("bp_count", tx_seen - base, 4);
    check("bp_b0", {24'h0, tx_log[base]},   32'h0D);
    check("bp_b3", {24'h0, tx_log[base+3]}, 32'hCA);

`ifdef RIB_TIMEOUT_EN
    // Grant never arrives
    send_frame('{8'h52, 8'h00, 8'h00, 8'h00, 8'h40});
    wait_req(ok);
    model_timeout();
    wait_idle();
    check("tmo_reqlen", req_lens[req_lens.size()-1], TMO);
    check("tmo_err_lit", {24'h0, tx_log[tx_log.size()-1]}, 32'h45);
    // Response in the terminal-count cycle wins over the timeout
    send_frame('{8'h57, 8'h00, 8'h00, 8'h00, 8'h50, 8'h11, 8'h22, 8'h33, 8'h44});
    serve(0, TMO - 2, 32'h0);
    wait_idle();
    check("tmo_edge_ack_lit", {24'h0, tx_log[tx_log.size()-1]}, 32'h4B);
`else
    ok = 1'b1;
`endif

    repeat (4) tick();
    check("end_exp_req_empty", exp_req.size(), 0);
    check("end_exp_tx_empty",  exp_tx.size(), 0);
    check("end_pending_empty", pend_wr.size(), 0);
    check("end_idle", {31'h0, o_busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
